// File: rtl/nes_palette_pkg.sv
// Shared definitions for the NES palette memory: default sizes, the power-on
// palette table, the controller state type and the backdrop address fold.
package nes_palette_pkg;

  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned PAL_DEPTH  = 32;

  localparam logic [5:0] BLACK_IDX = 6'h0F;

  // Power-on palette, indexed by logical palette address.
  localparam logic [5:0] DEFAULT_PAL [PAL_DEPTH] = '{
    6'h0F, 6'h11, 6'h21, 6'h30, 6'h0F, 6'h0A, 6'h38, 6'h25,
    6'h0F, 6'h0A, 6'h1A, 6'h29, 6'h0F, 6'h0A, 6'h10, 6'h20,
    6'h0F, 6'h11, 6'h27, 6'h20, 6'h0F, 6'h2A, 6'h39, 6'h25,
    6'h0F, 6'h06, 6'h27, 6'h37, 6'h0F, 6'h0F, 6'h00, 6'h30
  };

  typedef enum logic [1:0] {
    StBoot,
    StIdle,
    StAck
  } pal_state_e;

  // Sprite backdrop slots (upper half, low two bits zero) alias the
  // background backdrop slots in the lower half.
  function automatic logic [15:0] fold_addr(input logic [15:0] addr,
                                            input int unsigned addr_w,
                                            input bit mirror);
    logic [15:0] msb;
    logic [15:0] res;
    msb = 16'h1 << (addr_w - 1);
    res = addr;
    if (mirror && (addr_w >= 3) && ((addr & msb) != 16'h0) && (addr[1:0] == 2'b00)) begin
      res = addr & ~msb;
    end
    return res;
  endfunction

  // Boot value for a palette slot; slots past the table load black.
  function automatic logic [5:0] boot_value(input logic [15:0] idx);
    logic [5:0] val;
    val = BLACK_IDX;
    if (idx < 16'(PAL_DEPTH)) begin
      val = DEFAULT_PAL[idx[4:0]];
    end
    return val;
  endfunction

endpackage

// File: rtl/nes_palette_ram.sv
// Writable NES palette memory. Loads the default palette after reset (busy=1
// meanwhile), then serves a 1-cycle pixel lookup port and a req/ack CPU port.
// Backdrop mirroring is applied to every access path when MIRROR=1.
// Optional feature: define NES_PALETTE_GREYSCALE_EN to add the greyscale input,
// which masks pixel lookups with 6'h30.
module nes_palette_ram
  import nes_palette_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = 6,
  parameter int unsigned BUS_W  = 8,
  parameter bit          MIRROR = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_en,
  input  logic [ADDR_W-1:0] pix_addr,
`ifdef NES_PALETTE_GREYSCALE_EN
  input  logic              greyscale,
`endif
  output logic [DATA_W-1:0] pix_color,
  output logic              pix_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [BUS_W-1:0]  cpu_wdata,
  output logic [BUS_W-1:0]  cpu_rdata,
  output logic              cpu_ack,
  output logic              busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

`ifdef NES_PALETTE_GREYSCALE_EN
  localparam logic [DATA_W-1:0] GREY_MASK = DATA_W'(6'h30);
`endif

  function automatic logic [ADDR_W-1:0] phys(input logic [ADDR_W-1:0] a);
    return ADDR_W'(fold_addr(16'(a), ADDR_W, MIRROR));
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  pal_state_e        state_q;
  logic [ADDR_W-1:0] cnt_q;
  // Cleared on acceptance; set once cpu_req is seen low, so a held request
  // is served only once.
  logic              armed_q;

  logic              cpu_take;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // Bus bits above DATA_W are not stored.
  logic unused_wdata;
  assign unused_wdata = ^cpu_wdata;

  assign cpu_take = (state_q == StIdle) && cpu_req && armed_q;

  // Select the single write source: boot loader or an accepted CPU write.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = phys(cnt_q);
    mem_wdata = DATA_W'(boot_value(16'(cnt_q)));
    unique case (state_q)
      StBoot: mem_we = 1'b1;
      StIdle: begin
        if (cpu_take && cpu_we) begin
          mem_we    = 1'b1;
          mem_waddr = phys(cpu_addr);
          mem_wdata = cpu_wdata[DATA_W-1:0];
        end
      end
      default: ;
    endcase
    // An access pending when reset hits is dropped.
    if (!rst_n) begin
      mem_we = 1'b0;
    end
  end

  // Palette storage; reads elsewhere see the pre-write value.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Pixel lookup path, live once boot has finished.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_color <= '0;
      pix_valid <= 1'b0;
    end else begin
      pix_valid <= 1'b0;
      if ((state_q != StBoot) && pix_en) begin
        pix_valid <= 1'b1;
`ifdef NES_PALETTE_GREYSCALE_EN
        pix_color <= greyscale ? (mem[phys(pix_addr)] & GREY_MASK) : mem[phys(pix_addr)];
`else
        pix_color <= mem[phys(pix_addr)];
`endif
      end
    end
  end

  // Boot sequencer and CPU handshake controller.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StBoot;
      cnt_q     <= '0;
      busy      <= 1'b1;
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
      armed_q   <= 1'b1;
    end else begin
      cpu_ack <= 1'b0;
      if (!cpu_req) begin
        armed_q <= 1'b1;
      end
      unique case (state_q)
        StBoot: begin
          cnt_q <= cnt_q + ADDR_W'(1);
          if (cnt_q == ADDR_W'(DEPTH - 1)) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
        end
        StIdle: begin
          if (cpu_take) begin
            state_q   <= StAck;
            cpu_ack   <= 1'b1;
            armed_q   <= 1'b0;
            cpu_rdata <= cpu_we ? '0 : BUS_W'(mem[phys(cpu_addr)]);
          end
        end
        StAck: state_q <= StIdle;
        default: state_q <= StBoot;
      endcase
    end
  end

endmodule

// File: tb/tb_nes_palette_ram.sv
// Scoreboard bench for nes_palette_ram: stimulus pushes expected pixel and CPU
// responses from a flat reference palette; a negedge monitor pops and compares.
// Build with NES_PALETTE_GREYSCALE_EN defined to exercise the greyscale input.
module tb_nes_palette_ram;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pix_en;
  logic [4:0] pix_addr;
  logic [5:0] pix_color;
  logic       pix_valid;
  logic       cpu_req;
  logic       cpu_we;
  logic [4:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic [7:0] cpu_rdata;
  logic       cpu_ack;
  logic       busy;
`ifdef NES_PALETTE_GREYSCALE_EN
  logic       greyscale;
`endif

  always #5 clk = ~clk;

  nes_palette_ram #(
    .ADDR_W(5),
    .DATA_W(6),
    .BUS_W (8),
    .MIRROR(1'b1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pix_en   (pix_en),
    .pix_addr (pix_addr),
`ifdef NES_PALETTE_GREYSCALE_EN
    .greyscale(greyscale),
`endif
    .pix_color(pix_color),
    .pix_valid(pix_valid),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_ack  (cpu_ack),
    .busy     (busy)
  );

  localparam logic [5:0] BOOT_TAB [32] = '{
    6'h0F, 6'h11, 6'h21, 6'h30, 6'h0F, 6'h0A, 6'h38, 6'h25,
    6'h0F, 6'h0A, 6'h1A, 6'h29, 6'h0F, 6'h0A, 6'h10, 6'h20,
    6'h0F, 6'h11, 6'h27, 6'h20, 6'h0F, 6'h2A, 6'h39, 6'h25,
    6'h0F, 6'h06, 6'h27, 6'h37, 6'h0F, 6'h0F, 6'h00, 6'h30
  };

  int vectors     = 0;
  int miscompares = 0;

  logic [5:0] model [32];
  logic [5:0] exp_pix [$];
  logic [7:0] exp_cpu [$];

  bit         pend_we = 1'b0;
  int         pend_addr;
  logic [5:0] pend_data;

  // Backdrop aliasing: 0x10/0x14/0x18/0x1C are the same cells as 0x00/0x04/0x08/0x0C.
  function automatic int phys(input int a);
    if (a >= 16 && (a % 4) == 0) return a - 16;
    return a;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic load_defaults();
    for (int i = 0; i < 32; i++) model[i] = BOOT_TAB[i];
  endtask

  // One clock: present pixel stimulus, record its expectation, then commit any
  // CPU write issued for this same edge (pixel sees the old value).
  task automatic tick(input bit pe, input int pa);
    logic [5:0] e;
    pix_en   = pe;
    pix_addr = pa[4:0];
`ifdef NES_PALETTE_GREYSCALE_EN
    greyscale = 1'($urandom);
`endif
    if (pe) begin
      e = model[phys(pa)];
`ifdef NES_PALETTE_GREYSCALE_EN
      if (greyscale) e = e & 6'h30;
`endif
      exp_pix.push_back(e);
    end
    if (pend_we) begin
      model[pend_addr] = pend_data;
      pend_we = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_start(input bit we, input int a, input logic [7:0] d);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a[4:0];
    cpu_wdata = d;
    exp_cpu.push_back(we ? 8'h00 : {2'b00, model[phys(a)]});
    if (we) begin
      pend_we   = 1'b1;
      pend_addr = phys(a);
      pend_data = d[5:0];
    end
  endtask

  // Full handshake: raise req, wait (bounded) for ack, optionally keep req
  // high for extra cycles, then drop it for one cycle.
  task automatic cpu_access(input bit we, input int a, input logic [7:0] d,
                            input int hold, input bit rnd);
    int w = 0;
    cpu_start(we, a, d);
    do begin
      tick(rnd ? 1'($urandom) : 1'b0, int'($urandom % 32));
      w++;
    end while (cpu_ack !== 1'b1 && w < 6);
    if (cpu_ack !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL cpu_ack_timeout at %0t: got ack=%b expected 1 within 6 cycles", $time, cpu_ack);
    end
    repeat (hold) tick(rnd ? 1'($urandom) : 1'b0, int'($urandom % 32));
    cpu_req = 1'b0;
    tick(rnd ? 1'($urandom) : 1'b0, int'($urandom % 32));
  endtask

  task automatic do_reset(input int hold, input int boot_ticks);
    rst_n   = 1'b0;
    pix_en  = 1'b0;
    pend_we = 1'b0;
    repeat (hold) tick(1'b0, 0);
    cpu_req = 1'b0;
    rst_n   = 1'b1;
    load_defaults();
    repeat (boot_ticks) tick(1'b0, 0);
  endtask

  // Monitor: reset values, busy timing, pixel hold, and scoreboard pops.
  logic       rst_sampled = 1'b1;
  int         bcnt = 0;
  logic [5:0] last_pix = 6'h00;

  always @(posedge clk) rst_sampled <= rst_n;

  always @(negedge clk) begin
    logic [5:0] ep;
    logic [7:0] ec;
    if (rst_sampled === 1'b0) begin
      bcnt     = 0;
      last_pix = 6'h00;
      check("reset_values", {47'h0, pix_color, pix_valid, cpu_rdata, cpu_ack, busy},
            {47'h0, 6'h00, 1'b0, 8'h00, 1'b0, 1'b1});
    end else begin
      if (bcnt < 40) bcnt++;
      check("busy", 64'(busy), 64'(bcnt < 32));
      if (pix_valid === 1'b1) begin
        if (exp_pix.size() == 0) begin
          check("pix_unexpected_valid", 64'(pix_valid), 64'h0);
        end else begin
          ep = exp_pix.pop_front();
          check("pix_color", 64'(pix_color), 64'(ep));
          last_pix = ep;
        end
      end else begin
        check("pix_hold", 64'(pix_color), 64'(last_pix));
      end
      if (cpu_ack === 1'b1) begin
        if (exp_cpu.size() == 0) begin
          check("cpu_unexpected_ack", 64'(cpu_ack), 64'h0);
        end else begin
          ec = exp_cpu.pop_front();
          check("cpu_rdata", 64'(cpu_rdata), 64'(ec));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    pix_en    = 1'b0;
    pix_addr  = '0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
`ifdef NES_PALETTE_GREYSCALE_EN
    greyscale = 1'b0;
`endif
    load_defaults();

    do_reset(3, 32);

    // Default table lookups.
    tick(1'b1, 'h01);
    tick(1'b1, 'h02);
    tick(1'b1, 'h03);
    tick(1'b1, 'h1B);
    tick(1'b0, 0);

    // Backdrop mirroring.
    cpu_access(1'b1, 'h10, 8'h2C, 0, 1'b0);
    tick(1'b1, 'h00);
    cpu_access(1'b0, 'h1C, 8'h00, 0, 1'b0);

    // Handshake, truncation of wide write data, held request.
    cpu_access(1'b1, 'h05, 8'hFF, 0, 1'b0);
    cpu_access(1'b0, 'h05, 8'h00, 0, 1'b0);
    cpu_access(1'b0, 'h05, 8'h00, 4, 1'b0);

    // Same-edge CPU write and pixel read of one cell.
    cpu_start(1'b1, 'h07, 8'h16);
    tick(1'b1, 'h07);
    tick(1'b1, 'h07);
    cpu_req = 1'b0;
    tick(1'b0, 0);

    // Randomized mix of pixel lookups and CPU accesses.
    for (int i = 0; i < 250; i++) begin
      if (($urandom % 3) == 0) begin
        cpu_access(1'($urandom), int'($urandom % 32), 8'($urandom),
                   (($urandom % 4) == 0) ? 2 : 0, 1'b1);
      end else begin
        tick(1'($urandom), int'($urandom % 32));
      end
    end

    // Reset during boot, then a full boot restores defaults.
    do_reset(2, 10);
    do_reset(2, 32);
    for (int a = 0; a < 32; a++) tick(1'b1, a);

    // Reset while an ack is showing.
    cpu_start(1'b1, 'h03, 8'h12);
    tick(1'b0, 0);
    do_reset(2, 32);
    tick(1'b1, 'h03);

    // Request raised together with reset is dropped without an ack.
    cpu_req   = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = 5'h02;
    do_reset(3, 32);
    tick(1'b1, 'h02);

    for (int i = 0; i < 60; i++) begin
      if (($urandom % 3) == 0) begin
        cpu_access(1'($urandom), int'($urandom % 32), 8'($urandom), 0, 1'b1);
      end else begin
        tick(1'($urandom), int'($urandom % 32));
      end
    end

    repeat (3) tick(1'b0, 0);
    check("pix_queue_drained", 64'(exp_pix.size()), 64'h0);
    check("cpu_queue_drained", 64'(exp_cpu.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nes_palette_ram.md
# nes_palette_ram

Writable, parametrised NES palette memory that replaces the fixed per-game combinational palette ROMs. It holds the colour indices the PPU pixel pipeline looks up, boots itself from a default table after reset, applies NES backdrop mirroring, and accepts run-time CPU updates ($3F00-$3F1F style) through a req/ack port. It sits between the PPU register block and the pixel-to-RGB colour stage.

## Interface
Parameters:
- ADDR_W, 5, palette address width (depth = 2**ADDR_W entries)
- DATA_W, 6, stored colour-index width; bus bits above DATA_W read as 0
- BUS_W, 8, CPU data bus width (BUS_W >= DATA_W)
- MIRROR, 1, 1 = fold backdrop entries of upper half onto lower half; 0 = flat memory

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- pix_en  in  1  pixel lookup request
- pix_addr  in  ADDR_W  pixel palette address
- pix_color  out  DATA_W  looked-up colour index (registered)
- pix_valid  out  1  pix_color valid this cycle
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU palette address
- cpu_wdata  in  BUS_W  write data
- cpu_rdata  out  BUS_W  read data, valid with cpu_ack
- cpu_ack  out  1  one-cycle access completion pulse
- busy  out  1  1 while boot load in progress

## Operation
- Address folding (MIRROR=1): if addr[ADDR_W-1]=1 and addr[1:0]=0, physical address = addr with MSB cleared (0x10/0x14/0x18/0x1C -> 0x00/0x04/0x08/0x0C). Applied identically to pixel, CPU and boot paths. MIRROR=0: no folding.
- Storage: 2**ADDR_W x DATA_W register array; writes store cpu_wdata[DATA_W-1:0].
- FSM states: BOOT, IDLE, ACK.
  - BOOT: entered on reset. Counter 0..2**ADDR_W-1 writes DEFAULT_PAL[cnt] (folded) one entry per cycle; busy=1; cpu_req ignored (not acked); pix_valid=0. After last entry -> IDLE.
  - IDLE: cpu_req=1 -> perform access this cycle -> ACK.
  - ACK: cpu_ack=1, cpu_rdata driven (read: zero-extended stored value; write: 0). -> IDLE. A still-high cpu_req in ACK is not a new request; a new access needs cpu_req to drop for ≥1 cycle. Back-to-back rate: one access per 3 cycles.
- Pixel port independent of CPU port; active whenever FSM != BOOT.
- Same-cycle CPU write and pixel read of the same physical entry: pixel gets old value (read-before-write).
- Boot table depth < 2**ADDR_W: remaining entries loaded 0x0F (black).

## Timing
- Reset values: pix_color=0, pix_valid=0, cpu_rdata=0, cpu_ack=0, busy=1, boot counter=0.
- Boot: busy falls exactly 2**ADDR_W cycles after rst_n rises (32 cycles default).
- Pixel latency 1: pix_en at edge N -> pix_color/pix_valid at N+1; pix_valid=0 when pix_en=0 (pix_color holds last value).
- CPU: req sampled in IDLE at edge N -> write committed at N, cpu_ack/cpu_rdata at N+1 (1 cycle).
- Reset mid-boot or mid-access: aborts immediately, restarts BOOT; pending access is dropped with no ack.

## Configuration
- NES_PALETTE_GREYSCALE_EN defined: adds input port greyscale (1 bit); when 1, pix_color = stored value AND 6'h30 (PPUMASK bit 0 behaviour), sampled same cycle as pix_en. CPU reads unaffected.
- Undefined: no greyscale port; pix_color is the stored value.

## Structure
- Package nes_palette_pkg: PAL_DEPTH/ADDR_W defaults, BLACK_IDX=6'h0F, DEFAULT_PAL constant array (32 entries: 0F 11 21 30 0F 0A 38 25 0F 0A 1A 29 0F 0A 10 20 0F 11 27 20 0F 2A 39 25 0F 06 27 37 0F 0F 00 30), FSM state enum, fold_addr function.
- No sub-module; folding is a package function, array and FSM in one module.

## Test plan
- Boot: release rst_n, wait 32 cycles -> busy=0; pix reads 0x01,0x02,0x03,0x1B -> 0x11,0x21,0x30,0x37 (each 1 cycle after pix_en).
- Mirroring: CPU write 0x10 <- 0x2C -> pix read 0x00 returns 0x2C; CPU read 0x1C returns entry 0x0C (0x0F); MIRROR=0 build keeps 0x00 unchanged.
- CPU handshake: write 0x05 <- 0xFF -> ack 1 cycle later; read 0x05 -> cpu_rdata=0x3F; held req produces a single ack.
- Collision: same cycle CPU write 0x07 <- 0x16 and pix read 0x07 -> pix_color=0x25, next read 0x16.
- Reset mid-boot and mid-access: drop rst_n at boot cycle 10 / during ACK -> outputs return to reset values, no ack, full 32-cycle boot repeats, defaults restored.
- Greyscale (NES_PALETTE_GREYSCALE_EN): greyscale=1, pix read 0x02 (0x21) -> 0x20; greyscale=0 -> 0x21.
